keypad_scan_controller: RTL
===========================

# keypad_scan_controller

Scans a 4x4 matrix keypad, debounces it, and presents one encoded key per press to the processor core. It drives the rows one-hot, samples the column lines once per row dwell, and qualifies a single-key press over several full scans. It then holds the 4-bit key code in a one-entry buffer with a valid/acknowledge handshake. Key codes follow the keypad encoding used across the design: row bit i with column bit j gives code 4*i + j, so row 0001 / column 0001 is code 0 and row 1000 / column 1000 is code 15.

## Interface
- SCAN_DIV, 1000, clock cycles each row is driven before its columns are sampled; legal range is 4 or more.
- DEBOUNCE_SCANS, 4, consecutive identical full scans needed to accept a press or a release; legal range is 1 to 15.
- clock  input  1  system clock; every flop is on the rising edge.
- ResetN  input  1  reset, asynchronous and active-low.
- ColumnInput  input  4  raw column lines, active-high, asynchronous to clock.
- RowDrive  output  4  one-hot row drive.
- KeyCode  output  4  buffered key code; only meaningful while KeyValid is 1.
- KeyValid  output  1  buffer holds an unconsumed key.
- KeyAck  input  1  consumer pulse; clears KeyValid.
- KeyPressed  output  1  level; 1 while the debounced key is held.
- Overrun  output  1  sticky; a new key was accepted while KeyValid was 1.

## Operation
- **Reset values:** RowDrive=0001, KeyCode=0, KeyValid=0, KeyPressed=0, Overrun=0. RowIdx=0, DwellCnt=0, StableCnt=0, FSM=IDLE, synchronizer=0.
- **Synchronizer:** ColumnInput passes through a 2-flop synchronizer. Only the synchronized value (ColSync) is sampled.
- **Scan:**
  - DwellCnt counts 0..SCAN_DIV-1.
  - When DwellCnt=SCAN_DIV-1, ColSync is captured into the snapshot slot for RowIdx. In the same cycle RowIdx advances and wraps 3 to 0, and DwellCnt returns to 0.
  - RowDrive = 1 << RowIdx.
  - A scan end is the capture for RowIdx=3.
- **Scan classification** (evaluated at scan end over the 4 snapshot slots, with the row-3 slot taken from the current ColSync):
  - NONE: all 16 bits are 0.
  - SINGLE(K): exactly one bit is set; K = 4*row + col.
  - MULTI: two or more bits are set.
- **Debounce FSM.** It moves only at scan end.
  - IDLE:
    - SINGLE(K) sets Cand=K and StableCnt=1. If DEBOUNCE_SCANS=1 it goes straight to HELD; otherwise it goes to DEBOUNCE.
    - NONE or MULTI stays in IDLE.
  - DEBOUNCE:
    - SINGLE(Cand) increments StableCnt. When StableCnt reaches DEBOUNCE_SCANS, go to HELD and accept Cand.
    - Any other result goes to IDLE.
  - HELD:
    - KeyPressed=1.
    - NONE sets StableCnt=1 and goes to RELEASE; if DEBOUNCE_SCANS=1 it goes straight to IDLE.
    - SINGLE (any K) or MULTI stays in HELD. There is no roll-over: a second key is ignored until full release.
  - RELEASE:
    - KeyPressed stays 1.
    - NONE increments StableCnt. At DEBOUNCE_SCANS, go to IDLE and set KeyPressed=0.
    - SINGLE or MULTI returns to HELD and no new key is accepted.
- **Accept (entry into HELD from DEBOUNCE or IDLE):**
  - If KeyValid=0, or KeyAck=1 in the same cycle: KeyCode is loaded with Cand and KeyValid is 1 on the next cycle.
  - Otherwise: KeyCode and KeyValid are unchanged and Overrun is set to 1.
- **Handshake:**
  - KeyAck with KeyValid=1 and no accept in that cycle clears KeyValid on the next cycle. In the same cycle it clears Overrun.
  - KeyAck with KeyValid=0 has no effect.
- **Reset mid-operation:** all state returns to its reset values immediately. Any partially debounced key is discarded.

## Timing
- Scan period is 4*SCAN_DIV cycles.
- The synchronizer delay is 2 cycles. The SCAN_DIV >= 4 rule guarantees that columns settle within a dwell.
- **Press latency:** a key that is stable from the start of a scan is accepted at the end of scan number DEBOUNCE_SCANS. KeyValid rises 1 cycle after that scan end.
- **Release latency:** KeyPressed falls 1 cycle after the DEBOUNCE_SCANS-th consecutive NONE scan end.
- All outputs are registered. Nothing combinational passes from an input to an output.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=2, which gives a 16-cycle scan.

- **Reset state:** assert ResetN=0 mid-dwell. Outputs drop to RowDrive=0001, KeyValid=0, KeyPressed=0, Overrun=0 without waiting for a clock edge. After release, RowDrive steps 0001, 0010, 0100, 1000, 0001 every 4 cycles.
- **Single press:**
  - The model closes row 2 / column 1 (column bit 1 high while RowDrive=0100) for 5 scans.
  - Required: KeyCode=9 and KeyValid=1 one cycle after the 2nd scan end, and KeyPressed=1.
  - KeyAck pulse: KeyValid=0 on the next cycle.
  - Open the switch: KeyPressed=0 after 2 NONE scans.
- **Bounce rejection:** key 5 is present for 1 scan, absent for 1 scan, then present for 1 scan. Required: KeyValid stays 0.
- **Multi-key:** hold keys 0 and 15 together for 4 scans. Required: no accept. Then hold only key 15 for 2 scans. Required: KeyCode=15.
- **Overrun:**
  - Press and release key 3 with no ack, then press and release key 12.
  - Required: KeyCode stays 3 and Overrun=1.
  - KeyAck: KeyValid=0 and Overrun=0.
  - Also check that KeyAck in the same cycle as an accept loads the new code, keeps KeyValid=1, and leaves Overrun=0.
- **No roll-over:** hold key 7, then add key 8 while 7 is still held, then release 7 with 8 still held. Required: only 7 is delivered. Key 8 is accepted only after a full release followed by a re-press.

Source files
------------

// File: rtl/keypad_scan_controller.sv
// 4x4 matrix keypad scanner: one-hot row drive, per-row column capture, multi-scan
// debounce of a single key, and a one-entry key buffer with a valid/ack handshake.
module keypad_scan_controller #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clock,
    input  logic       ResetN,
    input  logic [3:0] ColumnInput,
    output logic [3:0] RowDrive,
    output logic [3:0] KeyCode,
    output logic       KeyValid,
    input  logic       KeyAck,
    output logic       KeyPressed,
    output logic       Overrun,
    output logic [1:0] DebugState
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [3:0] DEB_TARGET = 4'(DEBOUNCE_SCANS);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    logic [3:0]      ColMeta, ColSync;
    logic [DW-1:0]   DwellCnt;
    logic [1:0]      RowIdx;
    logic [3:0]      Snap0, Snap1, Snap2;
    logic            DwellEnd, ScanEnd;
    logic [15:0]     Grid;
    logic [4:0]      Ones;
    logic [3:0]      Code;
    logic            IsNone, IsSingle;
    logic [1:0]      State, StateNext;
    logic [3:0]      Cand, CandNext;
    logic [3:0]      StableCnt, StableNext, StableInc;
    logic            Accept, Ackd;
    logic [3:0]      AcceptCode;

    always_ff @(posedge clock or negedge ResetN) begin
        if (!ResetN) begin
            ColMeta <= '0;
            ColSync <= '0;
        end else begin
            ColMeta <= ColumnInput;
            ColSync <= ColMeta;
        end
    end

    assign DwellEnd = (DwellCnt == DWELL_LAST);
    assign ScanEnd  = DwellEnd && (RowIdx == 2'd3);

    // RowDrive is kept as its own rotating flop so it stays registered and equals 1 << RowIdx.
    always_ff @(posedge clock or negedge ResetN) begin
        if (!ResetN) begin
            DwellCnt <= '0;
            RowIdx   <= 2'd0;
            RowDrive <= 4'b0001;
            Snap0    <= '0;
            Snap1    <= '0;
            Snap2    <= '0;
        end else if (DwellEnd) begin
            DwellCnt <= '0;
            RowIdx   <= RowIdx + 2'd1;
            RowDrive <= {RowDrive[2:0], RowDrive[3]};
            case (RowIdx)
                2'd0:    Snap0 <= ColSync;
                2'd1:    Snap1 <= ColSync;
                2'd2:    Snap2 <= ColSync;
                default: ;
            endcase
        end else begin
            DwellCnt <= DwellCnt + 1'b1;
        end
    end

    // Row 3 is classified straight from ColSync at its own capture cycle.
    assign Grid = {ColSync, Snap2, Snap1, Snap0};

    always_comb begin
        Ones = 5'd0;
        Code = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (Grid[i]) begin
                Ones = Ones + 5'd1;
                Code = 4'(i);
            end
        end
    end

    assign IsNone    = (Ones == 5'd0);
    assign IsSingle  = (Ones == 5'd1);
    assign StableInc = StableCnt + 4'd1;

    always_comb begin
        StateNext  = State;
        CandNext   = Cand;
        StableNext = StableCnt;
        Accept     = 1'b0;
        AcceptCode = Cand;
        if (ScanEnd) begin
            case (State)
                ST_IDLE: begin
                    if (IsSingle) begin
                        CandNext   = Code;
                        StableNext = 4'd1;
                        AcceptCode = Code;
                        if (DEB_TARGET == 4'd1) begin
                            StateNext = ST_HELD;
                            Accept    = 1'b1;
                        end else begin
                            StateNext = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (IsSingle && (Code == Cand)) begin
                        StableNext = StableInc;
                        if (StableInc == DEB_TARGET) begin
                            StateNext = ST_HELD;
                            Accept    = 1'b1;
                        end
                    end else begin
                        StateNext = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    if (IsNone) begin
                        StableNext = 4'd1;
                        StateNext  = (DEB_TARGET == 4'd1) ? ST_IDLE : ST_RELEASE;
                    end
                end
                default: begin
                    if (IsNone) begin
                        StableNext = StableInc;
                        if (StableInc == DEB_TARGET) StateNext = ST_IDLE;
                    end else begin
                        StateNext = ST_HELD;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge ResetN) begin
        if (!ResetN) begin
            State      <= ST_IDLE;
            Cand       <= '0;
            StableCnt  <= '0;
            KeyPressed <= 1'b0;
        end else begin
            State      <= StateNext;
            Cand       <= CandNext;
            StableCnt  <= StableNext;
            KeyPressed <= (StateNext == ST_HELD) || (StateNext == ST_RELEASE);
        end
    end

    // Handshake: KeyValid rises the cycle after an accept and stays up until a cycle with
    // KeyAck=1; an ack coinciding with an accept hands over straight to the new code.
    // An accept that finds KeyValid=1 and no ack leaves the buffer alone and sets Overrun.
    assign Ackd = KeyAck && KeyValid;

    always_ff @(posedge clock or negedge ResetN) begin
        if (!ResetN) begin
            KeyCode  <= '0;
            KeyValid <= 1'b0;
            Overrun  <= 1'b0;
        end else begin
            if (Accept && (!KeyValid || KeyAck)) begin
                KeyCode  <= AcceptCode;
                KeyValid <= 1'b1;
            end else if (Ackd) begin
                KeyValid <= 1'b0;
            end
            if (Accept && KeyValid && !KeyAck) Overrun <= 1'b1;
            else if (Ackd)                     Overrun <= 1'b0;
        end
    end

    assign DebugState = State;

endmodule
